odo_round_key_sched: RTL and testbench

Sequential round-key scheduler that produces the 10-bit per-round keys consumed by the Odo round-key-application stage, one key per handshake. A 64-bit seed is expanded through a Galois LFSR, and the low 10 bits of the LFSR state form each round key. The block sits between the job/seed loader and the Odo round pipeline. It streams exactly ROUNDS keys per start request, under valid/ready flow control.

---
 rtl/odo_round_key_sched.sv | 76 +++++++
 tb/tb_odo_round_key_sched.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/odo_round_key_sched.sv
// Round-key scheduler: expands a 64-bit seed through a Galois LFSR and streams
// ROUNDS 10-bit keys under valid/ready, then pulses done for one cycle.
module odo_round_key_sched #(
  parameter int ROUNDS = 84
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [63:0] seed,
  output logic [9:0]  key,
  output logic        key_valid,
  input  logic        key_ready,
  output logic [6:0]  round,
  output logic        last,
  output logic        busy,
  output logic        done
);

  localparam logic [6:0]  LAST_RND = 7'(ROUNDS - 1);
  localparam logic [63:0] TAPS     = 64'hD800_0000_0000_0000;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [63:0] s;
  logic [63:0] s_adv;
  logic        hs;
  logic        at_last;

  assign hs      = (state == RUN) && key_ready;
  assign at_last = (round == LAST_RND);
  assign s_adv   = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // abort outranks both start and a same-cycle handshake
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!abort && start) state_nxt = RUN;
      RUN:     if (abort) state_nxt = IDLE;
               else if (hs && at_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s     <= '0;
      round <= '0;
    end else if (!abort) begin
      if (state == IDLE && start) begin
        // an all-zero seed would lock the LFSR at zero
        s     <= (seed == 64'h0) ? 64'h1 : seed;
        round <= '0;
      end else if (hs) begin
        s <= s_adv;
        if (!at_last) round <= round + 7'd1;
      end
    end
  end

  always_comb begin
    key       = s[9:0];
    key_valid = (state == RUN);
    busy      = (state == RUN);
    done      = (state == DONE);
    last      = (state == RUN) && at_last;
  end

endmodule

// File: tb/tb_odo_round_key_sched.sv
// Randomized self-checking bench for odo_round_key_sched against a
// seed-to-key-index reference model.
module tb_odo_round_key_sched;
  localparam int R = 84;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [63:0] seed = '0;
  logic [9:0]  key;
  logic        key_valid;
  logic        key_ready = 1'b0;
  logic [6:0]  round;
  logic        last;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  odo_round_key_sched #(.ROUNDS(R)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed),
    .key(key), .key_valid(key_valid), .key_ready(key_ready), .round(round),
    .last(last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Key number idx of a run started with seed sd: step the LFSR idx times.
  function automatic logic [9:0] model_key(input logic [63:0] sd, input int idx);
    logic [63:0] v;
    v = (sd == 0) ? 64'h1 : sd;
    for (int i = 0; i < idx; i++)
      v = v[0] ? ((v >> 1) ^ 64'hD800_0000_0000_0000) : (v >> 1);
    return v[9:0];
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; abort = 0; key_ready = 0;
    step(); step();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({key, key_valid, round, last, busy, done} !== 22'h0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: key=%h vld=%b rnd=%0d last=%b busy=%b done=%b want all 0",
                 c, key, key_valid, round, last, busy, done);
      end
      step();
    end
  endtask

  // Full run with key_ready=1; checks every key, last, and the done timing.
  task automatic full_run(input logic [63:0] sd, input string nm);
    seed = sd; start = 1; key_ready = 1;
    step();
    start = 0;
    for (int n = 0; n < R; n++) begin
      checks++;
      if (key_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || key !== model_key(sd, n) ||
          round !== 7'(n) || last !== (n == R - 1)) begin
        errors++;
        $display("FAIL %s key%0d: vld=%b busy=%b done=%b key=%h rnd=%0d last=%b want key=%h rnd=%0d last=%b",
                 nm, n, key_valid, busy, done, key, round, last, model_key(sd, n), n, (n == R - 1));
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || key_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: done=%b vld=%b busy=%b want 1 0 0", nm, done, key_valid, busy);
    end
    step();
    checks++;
    if (done !== 1'b0 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s done_one_cycle: done=%b vld=%b want 0 0", nm, done, key_valid);
    end
  endtask

  task automatic test_seed1();
    full_run(64'h1, "seed1");
  endtask

  task automatic test_seed0();
    seed = 64'h0; start = 1; key_ready = 0;
    step();
    start = 0;
    checks++;
    if (key !== 10'h001 || key_valid !== 1'b1) begin
      errors++;
      $display("FAIL seed0_key0: key=%h vld=%b want 001 1", key, key_valid);
    end
    abort = 1; step(); abort = 0;
    full_run(64'h0, "seed0");
  endtask

  task automatic test_backpressure();
    int n = 0, c = 0, dones = 0;
    logic [63:0] sd = {$urandom, $urandom} | 64'h3FF;
    seed = 64'h3FF; start = 1; key_ready = 0;
    step();
    start = 0;
    checks++;
    if (key !== 10'h3FF) begin
      errors++;
      $display("FAIL seed3ff_key0: key=%h want 3ff", key);
    end
    key_ready = 1; step();
    checks++;
    if (key !== 10'h1FF) begin
      errors++;
      $display("FAIL seed3ff_key1: key=%h want 1ff", key);
    end
    abort = 1; step(); abort = 0;
    for (int pass = 0; pass < 2; pass++) begin
      logic [63:0] cur = (pass == 0) ? 64'h3FF : sd;
      n = 0; c = 0; dones = 0;
      seed = cur; start = 1; key_ready = 0;
      step();
      start = 0;
      while (dones == 0 && c < 2000) begin
        key_ready = ($urandom_range(0, 2) != 0);
        if (done) dones++;
        else if (key_valid) begin
          checks++;
          if (key !== model_key(cur, n) || round !== 7'(n) || last !== (n == R - 1)) begin
            errors++;
            $display("FAIL bp%0d hs%0d: key=%h rnd=%0d last=%b want key=%h rnd=%0d",
                     pass, n, key, round, last, model_key(cur, n), n);
          end
          if (key_ready) n++;
        end
        step(); c++;
      end
      checks++;
      if (dones != 1 || n != R) begin
        errors++;
        $display("FAIL bp%0d count: handshakes=%0d done_seen=%0d want %0d 1", pass, n, dones, R);
      end
      key_ready = 0;
      step();
    end
  endtask

  task automatic test_abort();
    logic [63:0] sa = {$urandom, $urandom};
    logic [63:0] sb = {$urandom, $urandom};
    seed = sa; start = 1; key_ready = 1;
    step();
    start = 0;
    for (int n = 0; n < 20; n++) step();
    checks++;
    if (round !== 7'd20 || key !== model_key(sa, 20)) begin
      errors++;
      $display("FAIL abort_pre: rnd=%0d key=%h want 20 %h", round, key, model_key(sa, 20));
    end
    abort = 1; start = 1; seed = sb;
    step();
    abort = 0;
    checks++;
    if (key_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: vld=%b busy=%b done=%b want 0 0 0", key_valid, busy, done);
    end
    step();
    start = 0;
    checks++;
    if (key_valid !== 1'b1 || round !== 7'd0 || key !== model_key(sb, 0) || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_restart: vld=%b rnd=%0d key=%h done=%b want 1 0 %h 0",
               key_valid, round, key, done, model_key(sb, 0));
    end
    abort = 1; step(); abort = 0;
    checks++;
    if (done !== 1'b0 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_nodone: done=%b vld=%b want 0 0", done, key_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] s1 = {$urandom, $urandom};
    logic [63:0] s2 = {$urandom, $urandom};
    seed = s1; start = 1; key_ready = 1;
    step();
    seed = s2;
    for (int n = 0; n < R; n++) begin
      checks++;
      if (key_valid !== 1'b1 || key !== model_key(s1, n) || round !== 7'(n)) begin
        errors++;
        $display("FAIL b2b key%0d: vld=%b key=%h rnd=%0d want 1 %h %0d",
                 n, key_valid, key, round, model_key(s1, n), n);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: done=%b vld=%b want 1 0", done, key_valid);
    end
    step();
    checks++;
    if (done !== 1'b0 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: done=%b vld=%b want 0 0", done, key_valid);
    end
    step();
    start = 0;
    checks++;
    if (key_valid !== 1'b1 || round !== 7'd0 || key !== model_key(s2, 0)) begin
      errors++;
      $display("FAIL b2b_restart: vld=%b rnd=%0d key=%h want 1 0 %h",
               key_valid, round, key, model_key(s2, 0));
    end
    abort = 1; step(); abort = 0;
  endtask

  initial begin
    #1;
    test_reset();
    test_seed1();
    test_seed0();
    test_backpressure();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
